// File: rtl/tinker_exec_unit.sv
// Tinker execute unit: accepts one instruction per handshake, runs it against the
// internal register file and holds the result until the consumer takes it.
module tinker_exec_unit #(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic [1:0]      out_err,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = (SHW + 1 > 6) ? SHW + 1 : 6;

  localparam logic [4:0] OP_AND    = 5'h00;
  localparam logic [4:0] OP_OR     = 5'h01;
  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_NOT    = 5'h03;
  localparam logic [4:0] OP_SHFTR  = 5'h04;
  localparam logic [4:0] OP_SHFTRI = 5'h05;
  localparam logic [4:0] OP_SHFTL  = 5'h06;
  localparam logic [4:0] OP_SHFTLI = 5'h07;
  localparam logic [4:0] OP_MOV    = 5'h11;
  localparam logic [4:0] OP_MOVI   = 5'h12;
  localparam logic [4:0] OP_ADD    = 5'h18;
  localparam logic [4:0] OP_ADDI   = 5'h19;
  localparam logic [4:0] OP_SUB    = 5'h1A;
  localparam logic [4:0] OP_SUBI   = 5'h1B;
  localparam logic [4:0] OP_MUL    = 5'h1C;
  localparam logic [4:0] OP_DIV    = 5'h1D;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_ILL  = 2'd1;
  localparam logic [1:0] ERR_DIV0 = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [XLEN-1:0] regs_r [NUM_REGS];

  logic            in_ready_r, out_valid_r, we_r, is_mul_r;
  logic [4:0]      out_rd_r;
  logic [XLEN-1:0] out_data_r;
  logic [1:0]      out_err_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] a_r, b_r;
  logic [XLEN:0]   acc_r;

  logic [4:0]        opcode_s, rd_s, rs_s, rt_s;
  logic signed [11:0] imm_s;
  logic [XLEN-1:0]   simm_s, rs_v_s, rt_v_s, rd_v_s, alu_s;
  logic              uses_rs_s, uses_rt_s, known_s, is_iter_s, legal_s, div_zero_s;
  logic              accept_s, step_s, last_s, commit_s;
  logic [XLEN-1:0]   a_nxt_s, b_nxt_s, iter_res_s;
  logic [XLEN:0]     acc_nxt_s, rem_sh_s, diff_s;

  function automatic logic reg_ok(input logic [4:0] idx);
    return ({1'b0, idx} < 6'(NUM_REGS));
  endfunction

  assign opcode_s = instruction[31:27];
  assign rd_s     = instruction[26:22];
  assign rs_s     = instruction[21:17];
  assign rt_s     = instruction[16:12];
  assign imm_s    = instruction[11:0];
  assign simm_s   = XLEN'(imm_s);

  assign rs_v_s   = reg_ok(rs_s) ? regs_r[rs_s[RIW-1:0]] : {XLEN{1'b0}};
  assign rt_v_s   = reg_ok(rt_s) ? regs_r[rt_s[RIW-1:0]] : {XLEN{1'b0}};
  assign rd_v_s   = reg_ok(rd_s) ? regs_r[rd_s[RIW-1:0]] : {XLEN{1'b0}};
  assign dbg_data = reg_ok(dbg_addr) ? regs_r[dbg_addr[RIW-1:0]] : {XLEN{1'b0}};

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_rd    = out_rd_r;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;

  // Decode: single-cycle result, operand usage and legality of the offered instruction.
  always_comb begin
    uses_rs_s = 1'b1;
    uses_rt_s = 1'b1;
    known_s   = 1'b1;
    is_iter_s = 1'b0;
    alu_s     = {XLEN{1'b0}};
    case (opcode_s)
      OP_AND:    alu_s = rs_v_s & rt_v_s;
      OP_OR:     alu_s = rs_v_s | rt_v_s;
      OP_XOR:    alu_s = rs_v_s ^ rt_v_s;
      OP_NOT:    begin alu_s = ~rs_v_s; uses_rt_s = 1'b0; end
      OP_SHFTR:  alu_s = rs_v_s >> rt_v_s[SHW-1:0];
      OP_SHFTRI: begin alu_s = rd_v_s >> imm_s[SHW-1:0]; uses_rs_s = 1'b0; uses_rt_s = 1'b0; end
      OP_SHFTL:  alu_s = rs_v_s << rt_v_s[SHW-1:0];
      OP_SHFTLI: begin alu_s = rd_v_s << imm_s[SHW-1:0]; uses_rs_s = 1'b0; uses_rt_s = 1'b0; end
      OP_MOV:    begin alu_s = rs_v_s; uses_rt_s = 1'b0; end
      OP_MOVI:   begin alu_s = simm_s; uses_rs_s = 1'b0; uses_rt_s = 1'b0; end
      OP_ADD:    alu_s = rs_v_s + rt_v_s;
      OP_ADDI:   begin alu_s = rd_v_s + simm_s; uses_rs_s = 1'b0; uses_rt_s = 1'b0; end
      OP_SUB:    alu_s = rs_v_s - rt_v_s;
      OP_SUBI:   begin alu_s = rd_v_s - simm_s; uses_rs_s = 1'b0; uses_rt_s = 1'b0; end
      OP_MUL:    is_iter_s = 1'b1;
      OP_DIV:    is_iter_s = 1'b1;
      default:   known_s = 1'b0;
    endcase
  end

  assign legal_s    = known_s & reg_ok(rd_s) & (~uses_rs_s | reg_ok(rs_s)) &
                      (~uses_rt_s | reg_ok(rt_s));
  assign div_zero_s = (opcode_s == OP_DIV) && (rt_v_s == {XLEN{1'b0}});

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    step_s      = 1'b0;
    last_s      = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (legal_s && is_iter_s && !div_zero_s) begin
            state_nxt_s = S_ITER;
          end else begin
            state_nxt_s = S_DONE;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ITER: begin
        step_s = 1'b1;
        if (cnt_r == CW'(XLEN - 1)) begin
          last_s      = 1'b1;
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_ITER;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          commit_s    = 1'b1;
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // One iteration step: mul shifts the multiplicand up and the multiplier down;
  // div shifts the dividend out of a_r into the remainder and the quotient bit in.
  always_comb begin
    rem_sh_s  = {acc_r[XLEN-1:0], a_r[XLEN-1]};
    diff_s    = rem_sh_s - {1'b0, b_r};
    acc_nxt_s = acc_r;
    a_nxt_s   = a_r;
    b_nxt_s   = b_r;
    if (is_mul_r) begin
      if (b_r[0]) begin
        acc_nxt_s = acc_r + {1'b0, a_r};
      end else begin
        acc_nxt_s = acc_r;
      end
      a_nxt_s = a_r << 1;
      b_nxt_s = b_r >> 1;
    end else begin
      if (!diff_s[XLEN]) begin
        acc_nxt_s = diff_s;
        a_nxt_s   = {a_r[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt_s = rem_sh_s;
        a_nxt_s   = {a_r[XLEN-2:0], 1'b0};
      end
    end
    iter_res_s = is_mul_r ? acc_nxt_s[XLEN-1:0] : a_nxt_s;
  end

  // State register and the handshake flags derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == S_IDLE);
      out_valid_r <= (state_nxt_s == S_DONE);
    end
  end

  // Operand latch, iteration datapath, result registers and register-file commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
      out_rd_r   <= 5'd0;
      out_data_r <= {XLEN{1'b0}};
      out_err_r  <= ERR_OK;
      we_r       <= 1'b0;
      is_mul_r   <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      a_r        <= {XLEN{1'b0}};
      b_r        <= {XLEN{1'b0}};
      acc_r      <= {(XLEN+1){1'b0}};
    end else if (accept_s) begin
      out_rd_r <= rd_s;
      is_mul_r <= (opcode_s == OP_MUL);
      cnt_r    <= {CW{1'b0}};
      a_r      <= rs_v_s;
      b_r      <= rt_v_s;
      acc_r    <= {(XLEN+1){1'b0}};
      if (!legal_s) begin
        out_data_r <= {XLEN{1'b0}};
        out_err_r  <= ERR_ILL;
        we_r       <= 1'b0;
      end else if (div_zero_s) begin
        out_data_r <= {XLEN{1'b1}};
        out_err_r  <= ERR_DIV0;
        we_r       <= 1'b1;
      end else begin
        out_data_r <= alu_s;
        out_err_r  <= ERR_OK;
        we_r       <= 1'b1;
      end
    end else if (step_s) begin
      acc_r <= acc_nxt_s;
      a_r   <= a_nxt_s;
      b_r   <= b_nxt_s;
      cnt_r <= cnt_r + CW'(1);
      if (last_s) begin
        out_data_r <= iter_res_s;
      end
    end else if (commit_s && we_r) begin
      regs_r[out_rd_r[RIW-1:0]] <= out_data_r;
    end
  end

endmodule

// File: tb/tb_tinker_exec_unit.sv
// Randomised bench for tinker_exec_unit: every transaction is predicted by an
// arithmetic reference model with its own register array.
module tb_tinker_exec_unit;

  localparam int XLEN     = 64;
  localparam int NUM_REGS = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     instruction = 32'd0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;
  logic [1:0]      out_err;
  logic [4:0]      dbg_addr = 5'd0;
  logic [XLEN-1:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] m_regs [NUM_REGS];
  logic [4:0]  ops [16] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                            5'h11, 5'h12, 5'h18, 5'h19, 5'h1A, 5'h1B, 5'h1C, 5'h1D};

  tinker_exec_unit #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_data(out_data), .out_err(out_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [11:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  function automatic logic [63:0] rv(input logic [4:0] idx);
    return (int'(idx) < NUM_REGS) ? m_regs[idx[3:0]] : 64'd0;
  endfunction

  // Architectural prediction: result, error code, write enable and latency.
  function automatic void model(input logic [31:0] ins, output logic [63:0] d,
                                output logic [1:0] e, output bit we, output int lat);
    logic [4:0] op, rd, rs, rt;
    logic signed [11:0] imm;
    logic [63:0] a, b, c, simm;
    bit urs, urt, known, legal;
    op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12]; imm = ins[11:0];
    simm = 64'(imm);
    a = rv(rs); b = rv(rt); c = rv(rd);
    urs = 1; urt = 1; known = 1; lat = 1; d = 64'd0;
    case (op)
      5'h00: d = a & b;
      5'h01: d = a | b;
      5'h02: d = a ^ b;
      5'h03: begin d = ~a; urt = 0; end
      5'h04: d = a >> b[5:0];
      5'h05: begin d = c >> ins[5:0]; urs = 0; urt = 0; end
      5'h06: d = a << b[5:0];
      5'h07: begin d = c << ins[5:0]; urs = 0; urt = 0; end
      5'h11: begin d = a; urt = 0; end
      5'h12: begin d = simm; urs = 0; urt = 0; end
      5'h18: d = a + b;
      5'h19: begin d = c + simm; urs = 0; urt = 0; end
      5'h1A: d = a - b;
      5'h1B: begin d = c - simm; urs = 0; urt = 0; end
      5'h1C: begin d = a * b; lat = XLEN + 1; end
      5'h1D: begin
        if (b == 64'd0) d = {64{1'b1}};
        else begin d = a / b; lat = XLEN + 1; end
      end
      default: known = 0;
    endcase
    legal = known && (int'(rd) < NUM_REGS) && (!urs || int'(rs) < NUM_REGS) &&
            (!urt || int'(rt) < NUM_REGS);
    if (!legal) begin
      d = 64'd0; e = 2'd1; we = 0; lat = 1;
    end else if (op == 5'h1D && b == 64'd0) begin
      e = 2'd2; we = 1;
    end else begin
      e = 2'd0; we = 1;
    end
  endfunction

  // Issue one instruction, wait for its result, optionally stall, then commit.
  task automatic exec(input logic [31:0] ins, input int stall, output logic [63:0] got);
    logic [63:0] ed, old_rd;
    logic [1:0]  ee;
    bit ewe, busy_rdy, hold_ok;
    int elat, lat, a;
    model(ins, ed, ee, ewe, elat);
    old_rd = rv(ins[26:22]);
    @(negedge clk);
    check("idle_ready", in_ready, 64'd1);
    in_valid = 1'b1; instruction = ins;
    @(posedge clk);
    lat = 0; busy_rdy = 0;
    while (lat <= XLEN + 8) begin
      @(negedge clk);
      lat++;
      in_valid = 1'($urandom_range(0, 1)); instruction = $urandom;
      busy_rdy |= in_ready;
      if (out_valid) break;
    end
    check("latency", 64'(lat), 64'(elat));
    check("busy_ready_low", 64'(busy_rdy), 64'd0);
    check("out_data", out_data, ed);
    check("out_err", out_err, ee);
    check("out_rd", out_rd, ins[26:22]);
    got = out_data;
    hold_ok = 1;
    dbg_addr = ins[26:22];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1)); instruction = $urandom;
      hold_ok &= (out_valid === 1'b1) && (in_ready === 1'b0) && (out_data === ed) &&
                 (out_err === ee) && (out_rd === ins[26:22]) && (dbg_data === old_rd);
    end
    if (stall > 0) check("stall_hold", 64'(hold_ok), 64'd1);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (ewe) m_regs[ins[25:22]] = ed;
    check("post_valid", out_valid, 64'd0);
    check("post_ready", in_ready, 64'd1);
    dbg_addr = ins[26:22];
    #1 check("dbg_rd", dbg_data, rv(ins[26:22]));
    a = $urandom_range(0, 31);
    dbg_addr = 5'(a);
    #1 check("dbg_rand", dbg_data, rv(5'(a)));
  endtask

  initial begin
    logic [63:0] r;
    logic [4:0] op, rd, rs, rt;
    int k;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 64'd0;

    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 64'd0);
    check("rst_ready", in_ready, 64'd1);
    check("rst_data", out_data, 64'd0);
    check("rst_err", out_err, 64'd0);
    check("rst_rd", out_rd, 64'd0);
    rst = 1'b1;

    exec(enc(5'h12, 5'd1, 5'd0, 5'd0, 12'h7FF), 0, r);
    check("movi_pos", r, 64'h0000_0000_0000_07FF);
    exec(enc(5'h12, 5'd2, 5'd0, 5'd0, 12'h800), 0, r);
    check("movi_neg", r, 64'hFFFF_FFFF_FFFF_F800);
    dbg_addr = 5'd2;
    #1 check("dbg_r2", dbg_data, 64'hFFFF_FFFF_FFFF_F800);

    exec(enc(5'h12, 5'd1, 5'd0, 5'd0, 12'd6), 0, r);
    exec(enc(5'h12, 5'd2, 5'd0, 5'd0, 12'd7), 0, r);
    exec(enc(5'h1C, 5'd3, 5'd1, 5'd2, 12'd0), 0, r);
    check("mul_6x7", r, 64'd42);

    exec(enc(5'h12, 5'd1, 5'd0, 5'd0, 12'd100), 0, r);
    exec(enc(5'h1D, 5'd4, 5'd1, 5'd2, 12'd0), 0, r);
    check("div_100_7", r, 64'd14);
    exec(enc(5'h12, 5'd2, 5'd0, 5'd0, 12'd0), 0, r);
    exec(enc(5'h1D, 5'd4, 5'd1, 5'd2, 12'd0), 0, r);
    check("div_zero", r, {64{1'b1}});

    exec(enc(5'h14, 5'd1, 5'd2, 5'd3, 12'd0), 0, r);
    exec(enc(5'h12, 5'd20, 5'd0, 5'd0, 12'd5), 0, r);
    dbg_addr = 5'd1;
    #1 check("illegal_keep_r1", dbg_data, 64'd100);

    exec(enc(5'h12, 5'd1, 5'd0, 5'd0, 12'h00F), 0, r);
    exec(enc(5'h07, 5'd1, 5'd0, 5'd0, 12'd4), 0, r);
    check("shftli", r, 64'hF0);
    exec(enc(5'h12, 5'd1, 5'd0, 5'd0, 12'd0), 0, r);
    exec(enc(5'h1B, 5'd1, 5'd0, 5'd0, 12'd1), 0, r);
    check("subi_wrap", r, {64{1'b1}});
    exec(enc(5'h18, 5'd5, 5'd3, 5'd4, 12'd0), 10, r);

    // Reset in the middle of a divide.
    exec(enc(5'h12, 5'd1, 5'd0, 5'd0, 12'd100), 0, r);
    exec(enc(5'h12, 5'd2, 5'd0, 5'd0, 12'd7), 0, r);
    @(negedge clk);
    in_valid = 1'b1; instruction = enc(5'h1D, 5'd6, 5'd1, 5'd2, 12'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 64'd0);
    check("midrst_data", out_data, 64'd0);
    check("midrst_err", out_err, 64'd0);
    check("midrst_rd", out_rd, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 64'd0;
    @(negedge clk);
    check("midrst_ready", in_ready, 64'd1);
    check("midrst_valid2", out_valid, 64'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 check("midrst_regs", dbg_data, 64'd0);
    end

    for (int t = 0; t < 160; t++) begin
      k = $urandom_range(0, 19);
      op = (k < 16) ? ops[k] : 5'($urandom_range(0, 31));
      rd = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
      rs = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
      rt = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
      exec(enc(op, rd, rs, rt, 12'($urandom)), $urandom_range(0, 3), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
